// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first.
// The rx pin is synchronised by two flops, then every FSM decision is taken
// from a short sample history of the synchronised line. A good frame loads
// data_out and pulses valid for one cycle. A low stop bit pulses frame_err
// once and the receiver then waits for the line to return high.
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority voting
// at each sample point. The default build takes a single sample.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_T = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_n;
  logic          sync_meta, rx_s;
  logic [2:0]    hist_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n;
  logic          line;
  logic          sample;

  // hist_q[0] is the line value the FSM acts on. hist_q[1] and hist_q[2]
  // hold the two previous cycles, which are the earlier majority votes.
  assign line = hist_q[0];

`ifdef UART_RX_MAJORITY_EN
  assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                  (hist_q[1] & hist_q[2]);
`else
  // The older history flops exist in both builds so that the register set
  // is the same. The single-sample decision does not use them.
  logic unused_hist;
  assign unused_hist = ^hist_q[2:1];
  assign sample      = hist_q[0];
`endif

  // Two-flop synchroniser followed by the sample history, all idle high.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
      hist_q    <= 3'b111;
    end else begin
      sync_meta <= rx;
      rx_s      <= sync_meta;
      hist_q    <= {hist_q[1:0], rx_s};
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      data_out  <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  // Next-state logic. Each timed state counts to its terminal value and
  // then acts on the sample. valid and frame_err come from mutually
  // exclusive branches of STOP, so they can never be high together.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    data_n  = data_out;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!line) state_n = START;
      end
      START: begin
        if (cnt == HALF_T) begin
          cnt_n = '0;
          if (sample) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            bit_n   = 3'd0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_T) begin
          cnt_n   = '0;
          shift_n = {sample, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_T) begin
          cnt_n = '0;
          if (sample) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (line) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at the default 434 clocks per bit.
// rx is driven on falling clock edges, so a frame started at the falling
// edge after rising edge n has E0 = n+1. A monitor records every valid and
// frame_err pulse with its cycle number. Each test task compares the
// results with hand-computed values.
module tb_uart_rx;

  localparam int CPB  = 434;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       nRst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  int cyc            = 0;
  int valid_cnt      = 0;
  int ferr_cnt       = 0;
  int both_cnt       = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_ferr_cyc  = 0;
  int drive_cyc      = 0;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
      obs_q.push_back(data_out);
    end
    if (frame_err) begin
      ferr_cnt      <= ferr_cnt + 1;
      last_ferr_cyc <= cyc;
    end
    if (valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic apply_reset();
    nRst = 1'b0;
    wait_cycles(3);
    nRst = 1'b1;
    wait_cycles(3);
  endtask

  // Drive one 8N1 frame starting at a falling edge. If glitch_bit is
  // 0..7, the line is forced high for one cycle at the point where the
  // first synchroniser flop takes that bit's terminal sample.
  task automatic send_byte(input logic [7:0] b, input int glitch_bit);
    drive_cyc = cyc;
    for (int j = 0; j < CPB; j++) begin rx = 1'b0; @(negedge clk); end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < CPB; j++) begin
        rx = (i == glitch_bit && j == HALF) ? 1'b1 : b[i];
        @(negedge clk);
      end
    end
    for (int j = 0; j < CPB; j++) begin rx = 1'b1; @(negedge clk); end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    rx   = 1'b1;
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    wait_cycles(3);
    checks++; if (dut.state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.state); end
    nRst = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_basic();
    int v0, f0;
    logic [7:0] got;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, -1);
    wait_cycles(3);
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL basic_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 != 0) begin failures++; $display("FAIL basic_ferr_count got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (last_valid_cyc != drive_cyc + 4127) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", last_valid_cyc - drive_cyc - 1, 4126); end
    checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", data_out); end
    got = 8'hxx;
    if (obs_q.size() > 0) got = obs_q.pop_front();
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL basic_strobe_data got=%h exp=a5", got); end
  endtask

  task automatic test_start_glitch();
    int v0, f0;
    logic [7:0] got;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_cycles(100);
    rx = 1'b1;
    wait_cycles(300);
    checks++; if (valid_cnt - v0 != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 != 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (dut.state !== 3'd0) begin failures++; $display("FAIL glitch_state got=%0d exp=0", dut.state); end
    send_byte(8'h3C, -1);
    wait_cycles(3);
    got = 8'hxx;
    if (obs_q.size() > 0) got = obs_q.pop_front();
    checks++; if (got !== 8'h3C) begin failures++; $display("FAIL glitch_next_data got=%h exp=3c", got); end
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL glitch_next_count got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_break();
    int v0, f0, d;
    logic [7:0] got;
    apply_reset();
    v0 = valid_cnt; f0 = ferr_cnt;
    d  = cyc;
    rx = 1'b0;
    wait_cycles(20 * CPB);
    checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL break_ferr_count got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (last_ferr_cyc != d + 4127) begin failures++; $display("FAIL break_ferr_time got=%0d exp=%0d", last_ferr_cyc - d - 1, 4126); end
    checks++; if (valid_cnt - v0 != 0) begin failures++; $display("FAIL break_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL break_data got=%h exp=00", data_out); end
    checks++; if (dut.state !== 3'd4) begin failures++; $display("FAIL break_wait_state got=%0d exp=4", dut.state); end
    rx = 1'b1;
    wait_cycles(50);
    checks++; if (dut.state !== 3'd0) begin failures++; $display("FAIL break_idle_state got=%0d exp=0", dut.state); end
    send_byte(8'h81, -1);
    wait_cycles(3);
    got = 8'hxx;
    if (obs_q.size() > 0) got = obs_q.pop_front();
    checks++; if (got !== 8'h81) begin failures++; $display("FAIL break_next_data got=%h exp=81", got); end
    checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL break_ferr_total got=%0d exp=1", ferr_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [7:0] got, exp_b;
    v0 = valid_cnt;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    send_byte(8'h55, -1);
    send_byte(8'h0F, -1);
    wait_cycles(3);
    checks++; if (valid_cnt - v0 != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", valid_cnt - v0); end
    checks++; if (last_valid_cyc - prev_valid_cyc != 4340) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4340", last_valid_cyc - prev_valid_cyc); end
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      got   = 8'hxx;
      if (obs_q.size() > 0) got = obs_q.pop_front();
      checks++; if (got !== exp_b) begin failures++; $display("FAIL b2b_data got=%h exp=%h", got, exp_b); end
    end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    logic [7:0] got;
    v0 = valid_cnt; f0 = ferr_cnt;
    for (int j = 0; j < CPB; j++) begin rx = 1'b0; @(negedge clk); end
    rx = 1'b1;
    wait_cycles(4 * CPB + HALF);
    nRst = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
    checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_pulses got=%b%b exp=00", valid, frame_err); end
    checks++; if (dut.state !== 3'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", dut.state); end
    wait_cycles(10);
    nRst = 1'b1;
    wait_cycles(6 * CPB);
    checks++; if (valid_cnt - v0 != 0 || ferr_cnt - f0 != 0) begin failures++; $display("FAIL rstmid_no_event got=%0d/%0d exp=0/0", valid_cnt - v0, ferr_cnt - f0); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rstmid_data_after got=%h exp=00", data_out); end
    send_byte(8'h12, -1);
    wait_cycles(3);
    got = 8'hxx;
    if (obs_q.size() > 0) got = obs_q.pop_front();
    checks++; if (got !== 8'h12) begin failures++; $display("FAIL rstmid_next_data got=%h exp=12", got); end
  endtask

  task automatic test_bit_glitch();
    logic [7:0] got, exp_b;
`ifdef UART_RX_MAJORITY_EN
    exp_b = 8'h00;
`else
    exp_b = 8'h08;
`endif
    send_byte(8'h00, 3);
    wait_cycles(3);
    got = 8'hxx;
    if (obs_q.size() > 0) got = obs_q.pop_front();
    checks++; if (got !== exp_b) begin failures++; $display("FAIL bit_glitch_data got=%h exp=%h", got, exp_b); end
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL valid_ferr_overlap got=%0d exp=0", both_cnt); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL extra_valid got=%0d exp=0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_bit_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
